// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared widths, FSM states and bus-owner encoding for mem_bus_ctrl
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF    = 16;
    localparam int DATA_W_DEF    = 16;
    localparam int MEM_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_req_slot.sv
// rtl/mem_req_slot.sv - one-entry request holding register with same-cycle bypass view
module mem_req_slot
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              free,
    output logic              pending,
    output logic              eff_valid,
    output logic              eff_we,
    output logic [ADDR_W-1:0] eff_addr,
    output logic [DATA_W-1:0] eff_wdata
);

    logic              valid_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // Capture into an empty slot; freeing wins so a request consumed in its own cycle never lingers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (free) begin
            valid_q <= 1'b0;
        end else if (req && !valid_q) begin
            valid_q <= 1'b1;
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // The arbiter sees either the held request or, when empty, the request arriving this cycle
    assign pending   = valid_q;
    assign eff_valid = valid_q | req;
    assign eff_we    = valid_q ? we_q    : we;
    assign eff_addr  = valid_q ? addr_q  : addr;
    assign eff_wdata = valid_q ? wdata_q : wdata;

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - IF/D arbiter and bus master for the registered 16x16 memory; MEM_BUS_CTRL_BOUNDS_EN enables the address bounds check
module mem_bus_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] Abus,
    output logic [DATA_W-1:0] Dbusout,
    input  logic [DATA_W-1:0] Dbusin,
    output logic              memrd,
    output logic              memwr
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

    state_t state;
    owner_t owner;

    logic              if_pending, if_eff_valid, if_eff_we, if_free;
    logic [ADDR_W-1:0] if_eff_addr;
    logic [DATA_W-1:0] if_eff_wdata;
    logic              d_pending, d_eff_valid, d_eff_we, d_free;
    logic [ADDR_W-1:0] d_eff_addr;
    logic [DATA_W-1:0] d_eff_wdata;

    logic              sel_d, sel_valid, sel_we, sel_oob, bounds_en;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if_slot (
        .clk       (clk),
        .rst       (rst),
        .req       (if_req),
        .we        (1'b0),
        .addr      (if_addr),
        .wdata     ('0),
        .free      (if_free),
        .pending   (if_pending),
        .eff_valid (if_eff_valid),
        .eff_we    (if_eff_we),
        .eff_addr  (if_eff_addr),
        .eff_wdata (if_eff_wdata)
    );

    mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_d_slot (
        .clk       (clk),
        .rst       (rst),
        .req       (d_req),
        .we        (d_we),
        .addr      (d_addr),
        .wdata     (d_wdata),
        .free      (d_free),
        .pending   (d_pending),
        .eff_valid (d_eff_valid),
        .eff_we    (d_eff_we),
        .eff_addr  (d_eff_addr),
        .eff_wdata (d_eff_wdata)
    );

`ifdef MEM_BUS_CTRL_BOUNDS_EN
    assign bounds_en = 1'b1;
`else
    assign bounds_en = 1'b0;
`endif

    // D always wins; IF waits at most one D access because the D requester stalls until done
    always_comb begin
        sel_d     = d_eff_valid;
        sel_valid = d_eff_valid | if_eff_valid;
        sel_we    = d_eff_valid ? d_eff_we    : if_eff_we;
        sel_addr  = d_eff_valid ? d_eff_addr  : if_eff_addr;
        sel_wdata = d_eff_valid ? d_eff_wdata : if_eff_wdata;
        sel_oob   = bounds_en && ({1'b0, sel_addr} >= DEPTH_L);
    end

    // A slot is released when its access completes, or straight away when it fails the bounds check
    always_comb begin
        d_free  = ((state == IDLE) && sel_valid && sel_d && sel_oob)
                || ((state == CAP) && (owner == OWN_D))
                || (state == WR);
        if_free = ((state == IDLE) && sel_valid && !sel_d && sel_oob)
                || ((state == CAP) && (owner == OWN_IF));
    end

    assign busy = (state != IDLE) || if_pending || d_pending;

    // Bus FSM: all strobes, address/data and completion pulses are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= OWN_IF;
            Abus     <= '0;
            Dbusout  <= '0;
            memrd    <= 1'b0;
            memwr    <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
            if_done  <= 1'b0;
            d_done   <= 1'b0;
            err      <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        if (sel_oob) begin
                            err <= 1'b1;
                            if (sel_d) begin
                                d_done  <= 1'b1;
                                d_rdata <= '0;
                            end else begin
                                if_done  <= 1'b1;
                                if_rdata <= '0;
                            end
                        end else begin
                            Abus  <= sel_addr;
                            owner <= sel_d ? OWN_D : OWN_IF;
                            if (sel_we) begin
                                Dbusout <= sel_wdata;
                                memwr   <= 1'b1;
                                state   <= WR;
                            end else begin
                                memrd <= 1'b1;
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    memrd <= 1'b0;
                    state <= CAP;
                end
                CAP: begin
                    if (owner == OWN_D) begin
                        d_rdata <= Dbusin;
                        d_done  <= 1'b1;
                    end else begin
                        if_rdata <= Dbusin;
                        if_done  <= 1'b1;
                    end
                    state <= IDLE;
                end
                WR: begin
                    memwr  <= 1'b0;
                    d_done <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
